// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Position of the R/W flag within the address byte.
  localparam int unsigned RW_BIT = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser, optional glitch filter and edge detector for one bus line.
// Optional filter compiled in with I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev_q;

  // Metastability chain; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (FILTER_ON && (FILTER_LEN >= 2)) begin : g_filter
    logic [FILTER_LEN-1:0] hist_q;
    logic                  filt_q;

    // Filtered level follows only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
      if (rst) begin
        hist_q <= '1;
        filt_q <= 1'b1;
      end else begin
        hist_q <= {hist_q[FILTER_LEN-2:0], sync_out};
        if (&hist_q) begin
          filt_q <= 1'b1;
        end else if (~|hist_q) begin
          filt_q <= 1'b0;
        end
      end
    end

    assign level = filt_q;
  end else begin : g_direct
    assign level = sync_out;
  end

  // Previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with pointer-addressed byte register file and host port.
// Optional SCL/SDA glitch filter compiled in with I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic                        busy,
  input  logic                        host_we,
  input  logic [$clog2(NUM_REGS)-1:0] host_idx,
  input  logic [7:0]                  host_wdata,
  output logic [7:0]                  host_rdata,
  output logic                        i2c_wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] i2c_wr_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_c, stop_c;

  i2c_state_t       state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n, shift_in;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic             sda_oe_n;
  logic             rx_ack, rx_ack_n;
  logic             wr_pulse_n;
  logic [IDX_W-1:0] wr_idx_n;
  logic             bus_we;
  logic [IDX_W-1:0] bus_idx;
  logic [7:0]       bus_data;

  logic [7:0] regs [NUM_REGS];

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (scl_in),
    .level   (scl_s),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (sda_in),
    .level   (sda_s),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start_c  = sda_fall & scl_s;
  assign stop_c   = sda_rise & scl_s;
  assign shift_in = {shift[6:0], sda_s};

  assign busy       = (state != ST_IDLE);
  assign host_rdata = regs[host_idx];

  // Protocol state register and bus-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      ptr          <= '0;
      sda_oe       <= 1'b0;
      rx_ack       <= NACK;
      i2c_wr_pulse <= 1'b0;
      i2c_wr_idx   <= '0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      shift        <= shift_n;
      ptr          <= ptr_n;
      sda_oe       <= sda_oe_n;
      rx_ack       <= rx_ack_n;
      i2c_wr_pulse <= wr_pulse_n;
      i2c_wr_idx   <= wr_idx_n;
    end
  end

  // Next-state logic: bus conditions first, then bit sampling on SCL rise
  // and SDA drive changes on SCL fall.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    ptr_n      = ptr;
    sda_oe_n   = sda_oe;
    rx_ack_n   = rx_ack;
    wr_pulse_n = 1'b0;
    wr_idx_n   = i2c_wr_idx;
    bus_we     = 1'b0;
    bus_idx    = ptr;
    bus_data   = shift_in;

    if (start_c) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_c) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && (bit_cnt == 4'd8)) begin
            bit_cnt_n = '0;
            if (shift[7:1] == SLAVE_ADDR) begin
              state_n  = ST_ADDR_ACK;
              sda_oe_n = ~ACK;
            end else begin
              state_n  = ST_IGNORE;
              sda_oe_n = 1'b0;
            end
          end
        end

        ST_ADDR_ACK: begin
          // shift still holds the address byte, so the R/W flag is read here.
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (shift[RW_BIT]) begin
              state_n  = ST_RDATA;
              shift_n  = regs[ptr];
              sda_oe_n = ~regs[ptr][7];
            end else begin
              state_n  = ST_PTR;
              sda_oe_n = 1'b0;
            end
          end
        end

        ST_PTR: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && (bit_cnt == 4'd8)) begin
            bit_cnt_n = '0;
            ptr_n     = shift[IDX_W-1:0];
            state_n   = ST_PTR_ACK;
            sda_oe_n  = ~ACK;
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            state_n   = ST_WDATA;
            sda_oe_n  = 1'b0;
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bus_we     = 1'b1;
              wr_pulse_n = 1'b1;
              wr_idx_n   = ptr;
              ptr_n      = ptr + 1'b1;
            end
          end else if (scl_fall && (bit_cnt == 4'd8)) begin
            bit_cnt_n = '0;
            state_n   = ST_WDATA_ACK;
            sda_oe_n  = ~ACK;
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt_n = '0;
              state_n   = ST_RDATA_ACK;
              sda_oe_n  = 1'b0;
              ptr_n     = ptr + 1'b1;
            end else begin
              shift_n  = {shift[6:0], 1'b0};
              sda_oe_n = ~shift[6];
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            rx_ack_n = sda_s;
          end else if (scl_fall) begin
            bit_cnt_n = '0;
            if (rx_ack == NACK) begin
              state_n  = ST_IGNORE;
              sda_oe_n = 1'b0;
            end else begin
              state_n  = ST_RDATA;
              shift_n  = regs[ptr];
              sda_oe_n = ~regs[ptr][7];
            end
          end
        end

        default: begin
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // Register file: bus write has priority over a host write to the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (bus_we) begin
        regs[bus_idx] <= bus_data;
      end
      if (host_we && !(bus_we && (bus_idx == host_idx))) begin
        regs[host_idx] <= host_wdata;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed self-checking bench for i2c_slave_regfile acting as a bus master.
// Glitch-filter step runs only when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module tb_i2c_slave_regfile;

  localparam int Q = 8;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, busy;
  logic       host_we;
  logic [1:0] host_idx;
  logic [7:0] host_wdata, host_rdata;
  logic       i2c_wr_pulse;
  logic [1:0] i2c_wr_idx;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  logic [1:0] last_idx = '0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(
    .SLAVE_ADDR  (7'h48),
    .NUM_REGS    (4),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe       (sda_oe),
    .busy         (busy),
    .host_we      (host_we),
    .host_idx     (host_idx),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .i2c_wr_pulse (i2c_wr_pulse),
    .i2c_wr_idx   (i2c_wr_idx)
  );

  always @(posedge clk) begin
    if (!rst && i2c_wr_pulse) begin
      pulse_cnt = pulse_cnt + 1;
      last_idx  = i2c_wr_idx;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(H / 2);
    if (glitch) begin
      scl_m = 1'b0; tick(1);
      scl_m = 1'b1;
    end
    tick(H / 2);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch_bit == i);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(H / 2);
    ack = sda_line;
    tick(H / 2);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(H / 2);
      b[i] = sda_line;
      tick(H / 2);
      scl_m = 1'b0; tick(Q);
    end
    send_bit(master_ack, 1'b0);
  endtask

  task automatic host_write(input logic [1:0] idx, input logic [7:0] d);
    @(negedge clk);
    host_idx = idx; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    @(negedge clk);
    host_idx = idx;
    #1;
    check(tag, {24'd0, host_rdata}, {24'd0, exp});
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         p0;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    host_we = 1'b0; host_idx = '0; host_wdata = '0;
    tick(4);
    rst = 1'b0;
    tick(2);

    // Reset state
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_pulse", {31'd0, i2c_wr_pulse}, 32'd0);
    check("rst_wr_idx", {30'd0, i2c_wr_idx}, 32'd0);
    check_reg("rst_reg0", 2'd0, 8'h00);
    check_reg("rst_reg3", 2'd3, 8'h00);

    // Test 1: single write to reg[1]
    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h90, -1, ack); check("t1_addr_ack", {31'd0, ack}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h01, -1, ack); check("t1_ptr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'hA5, -1, ack); check("t1_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    tick(4);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t1_pulse_cnt", pulse_cnt - p0, 32'd1);
    check("t1_pulse_idx", {30'd0, last_idx}, 32'd1);
    check_reg("t1_reg1", 2'd1, 8'hA5);

    // Test 2: auto-increment with pointer wrap
    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h90, -1, ack); check("t2_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h03, -1, ack);
    send_byte(8'h11, -1, ack); check("t2_d0_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h22, -1, ack); check("t2_d1_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    tick(4);
    check("t2_pulse_cnt", pulse_cnt - p0, 32'd2);
    check("t2_last_idx", {30'd0, last_idx}, 32'd0);
    check_reg("t2_reg3", 2'd3, 8'h11);
    check_reg("t2_reg0", 2'd0, 8'h22);
    check_reg("t2_reg1_kept", 2'd1, 8'hA5);

    // Test 3: pointer write, repeated START, sequential read
    host_write(2'd0, 8'h5A);
    host_write(2'd1, 8'hC3);
    i2c_start();
    send_byte(8'h90, -1, ack);
    send_byte(8'h00, -1, ack); check("t3_ptr_ack", {31'd0, ack}, 32'd0);
    i2c_start();
    send_byte(8'h91, -1, ack); check("t3_raddr_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b0, rd); check("t3_rd0", {24'd0, rd}, 32'h5A);
    read_byte(1'b1, rd); check("t3_rd1", {24'd0, rd}, 32'hC3);
    tick(2);
    check("t3_sda_released", {31'd0, sda_oe}, 32'd0);
    check("t3_busy_ignore", {31'd0, busy}, 32'd1);
    i2c_stop();
    tick(4);
    check("t3_busy_after_stop", {31'd0, busy}, 32'd0);

    // Test 4: foreign address is not acknowledged
    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h92, -1, ack); check("t4_addr_nack", {31'd0, ack}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00, -1, ack); check("t4_byte_nack", {31'd0, ack}, 32'd1);
    check("t4_busy2", {31'd0, busy}, 32'd1);
    i2c_stop();
    tick(4);
    check("t4_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t4_no_pulse", pulse_cnt - p0, 32'd0);
    check_reg("t4_reg0", 2'd0, 8'h5A);
    check_reg("t4_reg3", 2'd3, 8'h11);

    // Test 5: reset in the middle of a data byte
    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h90, -1, ack);
    send_byte(8'h02, -1, ack); check("t5_ptr_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick(1);
    check("t5_sda_oe_rst", {31'd0, sda_oe}, 32'd0);
    check("t5_busy_rst", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
    check("t5_no_pulse", pulse_cnt - p0, 32'd0);
    check_reg("t5_reg2", 2'd2, 8'h00);
    check_reg("t5_reg3_cleared", 2'd3, 8'h00);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // Test 6: a one-clock SCL low glitch is filtered out
    i2c_start();
    send_byte(8'h90, 3, ack); check("t6_glitch_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h02, -1, ack);
    send_byte(8'h77, -1, ack);
    i2c_stop();
    tick(4);
    check_reg("t6_reg2", 2'd2, 8'h77);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
